mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, SHALL set the maximum number of WAIT cycles before an access is aborted (legal range 1..255).
REQ-002 clk  in  1  SHALL be the sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-004 mem_w  in  1  SHALL be the store request from the pipeline MEM stage.
REQ-005 mem_r  in  1  SHALL be the load request from the pipeline MEM stage.
REQ-006 addr  in  32  SHALL be the byte address (the ALU result).
REQ-007 wdata  in  32  SHALL be the store data, least-significant lanes used.
REQ-008 dmtype  in  3  SHALL be the access size: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned.
REQ-009 rdata  out  32  SHALL be the load result, extended to 32 bits.
REQ-010 stall  out  1  SHALL freeze the pipeline while high.
REQ-011 misalign  out  1  SHALL be a one-cycle misaligned-access flag.
REQ-012 bus_err  out  1  SHALL be a one-cycle timeout flag.
REQ-013 bus_req, bus_we  out  1 each  SHALL be the memory request and the write qualifier.
REQ-014 bus_addr  out  32  SHALL be the word-aligned address: {addr[31:2],2'b00}.
REQ-015 bus_be  out  4  SHALL be the byte-lane enables.
REQ-016 bus_wdata  out  32  SHALL be the lane-replicated write data.
REQ-017 bus_ack  in  1  and bus_rdata  in  32  SHALL be the memory completion strobe and the read word.

Function
REQ-018 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-019 An access SHALL be requested when mem_r|mem_w; if both are high, the access SHALL be a write.
REQ-020 Misalignment SHALL be defined as: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-021 In IDLE, on a misaligned request: misalign=1 combinationally, stall=0, no bus request, state remains IDLE.
REQ-022 In IDLE, on an aligned request: stall=1 combinationally, and the FSM SHALL move to WAIT and latch addr, wdata, dmtype and the write flag.
REQ-023 bus_req, bus_we, bus_addr, bus_be and bus_wdata SHALL be registered outputs, and SHALL be asserted and held stable for every WAIT cycle.
REQ-024 bus_be SHALL be: word 1111; half 0011<<(2*addr[1]); byte 0001<<addr[1:0].
REQ-025 bus_wdata SHALL be: word wdata; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
REQ-026 In WAIT, stall=1 and a cycle counter SHALL increment.
REQ-027 In WAIT, bus_ack=1 SHALL capture bus_rdata and move the FSM to DONE.
REQ-028 In WAIT, if the counter reaches ACK_TIMEOUT with bus_ack=0, the FSM SHALL move to DONE with error set.
REQ-029 If bus_ack arrives in the same cycle as the timeout, the ack SHALL win.
REQ-030 In DONE: stall=0, bus_req=0, rdata valid, bus_err=1 if error is set, then IDLE on the next cycle.
REQ-031 In DONE, request inputs SHALL be ignored; they still belong to the completing instruction.
REQ-032 rdata SHALL be the captured word >> (8*addr[1:0]), then extended: 000 none, 001 sign16, 010 zero16, 011 sign8, 100 zero8.
REQ-033 rdata SHALL be 0 after a store, after a timeout and after a misaligned access; it SHALL hold its value until the next completion.
REQ-034 Pipeline inputs SHALL NOT be sampled in WAIT; the latched copies SHALL be used.
REQ-035 Latency: aligned access issued in cycle 0 with ack in cycle k (k>=1) -> stall high in cycles 0..k, DONE in cycle k+1.

Reset
REQ-036 On reset=1 at a rising edge, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-037 On reset, bus_req, bus_we, bus_be and bus_err SHALL be 0, and bus_addr, bus_wdata and rdata SHALL be 0x00000000.
REQ-038 A reset arriving in WAIT or DONE SHALL abandon the access: bus_req=0 from the next cycle, and no bus_err or misalign SHALL be generated.
REQ-039 While reset=1, stall and misalign SHALL be 0.

Verification
REQ-040 lw at addr 0x100 with ack in cycle 1 and bus_rdata 0x12345678 -> bus_req high in cycle 1 only, stall high in cycles 0..1, rdata=0x12345678 in cycle 2.
REQ-041 lb at addr 0x103 with bus_rdata 0x80FF0000 -> rdata=0xFFFFFF80; lbu at the same address -> rdata=0x00000080.
REQ-042 sh at addr 0x102 with wdata 0x0000ABCD -> bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1.
REQ-043 lw at addr 0x101 -> misalign pulse in cycle 0, stall=0, bus_req never asserted.
REQ-044 lw with no ack and ACK_TIMEOUT=4 -> four WAIT cycles, DONE with bus_err=1 and rdata=0, then IDLE.
REQ-045 reset asserted during the 2nd WAIT cycle -> bus_req=0 and stall=0 on the next cycle, and a later ack is ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline MEM stage and a simple req/ack data bus.
// Handles lane alignment, sign/zero extension, misalignment and ack timeout.
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic        mem_r,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dmtype,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt_q;
  logic        err_q;
  logic        we_p0;
  logic [1:0]  addr_p0;
  logic [2:0]  dmtype_p0;

  logic        req;
  logic        is_word;
  logic        is_half;
  logic        mis;
  logic        timeout;

  function automatic logic [3:0] lane_be(input logic [2:0] dt, input logic [1:0] a);
    case (dt)
      3'd1, 3'd2: return 4'b0011 << {a[1], 1'b0};
      3'd3, 3'd4: return 4'b0001 << a;
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] dt, input logic [31:0] d);
    case (dt)
      3'd1, 3'd2: return {2{d[15:0]}};
      3'd3, 3'd4: return {4{d[7:0]}};
      default:    return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] a,
                                           input logic [2:0] dt);
    logic        [31:0] sh;
    logic signed [15:0] h;
    logic signed [7:0]  b;
    logic signed [31:0] ext;
    sh = word >> {a, 3'b000};
    h  = sh[15:0];
    b  = sh[7:0];
    case (dt)
      3'd1:    ext = h;
      3'd2:    ext = {16'h0000, sh[15:0]};
      3'd3:    ext = b;
      3'd4:    ext = {24'h000000, sh[7:0]};
      default: ext = sh;
    endcase
    return ext;
  endfunction

  assign req     = mem_r | mem_w;
  assign is_half = (dmtype == 3'd1) || (dmtype == 3'd2);
  assign is_word = !is_half && (dmtype != 3'd3) && (dmtype != 3'd4);
  assign mis     = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
  assign timeout = (cnt_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req && !mis) state_nxt = ST_WAIT;
      ST_WAIT: if (bus_ack || timeout) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    misalign = 1'b0;
    bus_err  = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          stall    = req && !mis;
          misalign = req && mis;
        end
        ST_WAIT: stall = 1'b1;
        ST_DONE: bus_err = err_q;
        default: ;
      endcase
    end
  end

  // Request capture in IDLE; WAIT works only from the latched copies
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'b0000;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      rdata     <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req && mis) begin
            rdata <= 32'h0;
          end else if (req) begin
            we_p0     <= mem_w;
            addr_p0   <= addr[1:0];
            dmtype_p0 <= dmtype;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            bus_req   <= 1'b1;
            bus_we    <= mem_w;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= lane_be(dmtype, addr[1:0]);
            bus_wdata <= lane_wdata(dmtype, wdata);
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (bus_ack || timeout) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_be  <= 4'b0000;
          end
          // Ack wins over a coincident timeout
          if (bus_ack) begin
            rdata <= we_p0 ? 32'h0 : load_ext(bus_rdata, addr_p0, dmtype_p0);
          end else if (timeout) begin
            err_q <= 1'b1;
            rdata <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_w, mem_r;
  logic [31:0] addr, wdata;
  logic [2:0]  dmtype;
  logic [31:0] rdata;
  logic        stall, misalign, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .mem_w(mem_w), .mem_r(mem_r), .addr(addr),
    .wdata(wdata), .dmtype(dmtype), .rdata(rdata), .stall(stall),
    .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic request(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] dt);
    mem_w = w; mem_r = r; addr = a; wdata = d; dmtype = dt;
  endtask

  initial begin
    reset = 1'b1; mem_w = 0; mem_r = 0; addr = 0; wdata = 0; dmtype = 0;
    bus_ack = 0; bus_rdata = 0;
    next_cycle();
    next_cycle();
    sample();
    check("rst_stall", 32'(stall), 0);
    check("rst_bus_req", 32'(bus_req), 0);
    check("rst_bus_be", 32'(bus_be), 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bus_err", 32'(bus_err), 0);
    next_cycle();
    reset = 1'b0;

    // lw 0x100, ack in cycle 1
    request(0, 1, 32'h100, 0, 3'd0);
    sample();
    check("lw_c0_stall", 32'(stall), 1);
    check("lw_c0_req", 32'(bus_req), 0);
    next_cycle();
    bus_ack = 1; bus_rdata = 32'h12345678;
    sample();
    check("lw_c1_req", 32'(bus_req), 1);
    check("lw_c1_stall", 32'(stall), 1);
    check("lw_c1_addr", bus_addr, 32'h100);
    check("lw_c1_be", 32'(bus_be), 32'hF);
    check("lw_c1_we", 32'(bus_we), 0);
    next_cycle();
    bus_ack = 0; bus_rdata = 0;
    sample();
    check("lw_c2_stall", 32'(stall), 0);
    check("lw_c2_req", 32'(bus_req), 0);
    check("lw_c2_rdata", rdata, 32'h12345678);
    next_cycle();
    request(0, 0, 0, 0, 3'd0);
    sample();
    check("lw_c3_stall", 32'(stall), 0);

    // lw 0x101 misaligned
    next_cycle();
    request(0, 1, 32'h101, 0, 3'd0);
    sample();
    check("mis_c0_flag", 32'(misalign), 1);
    check("mis_c0_stall", 32'(stall), 0);
    check("mis_c0_req", 32'(bus_req), 0);
    next_cycle();
    request(0, 0, 0, 0, 3'd0);
    sample();
    check("mis_c1_flag", 32'(misalign), 0);
    check("mis_c1_req", 32'(bus_req), 0);
    check("mis_rdata", rdata, 0);

    // sh 0x102 with mem_r also high: write wins
    next_cycle();
    request(1, 1, 32'h102, 32'h0000ABCD, 3'd1);
    sample();
    check("sh_c0_stall", 32'(stall), 1);
    next_cycle();
    bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
    sample();
    check("sh_be", 32'(bus_be), 32'hC);
    check("sh_wdata", bus_wdata, 32'hABCDABCD);
    check("sh_we", 32'(bus_we), 1);
    check("sh_addr", bus_addr, 32'h100);
    next_cycle();
    bus_ack = 0;
    sample();
    check("sh_done_rdata", rdata, 0);
    check("sh_done_stall", 32'(stall), 0);
    next_cycle();
    request(0, 0, 0, 0, 3'd0);

    // lb 0x103, inputs changed during WAIT must be ignored, ack in cycle 2
    request(0, 1, 32'h103, 0, 3'd3);
    next_cycle();
    request(0, 1, 32'h100, 0, 3'd0);
    sample();
    check("lb_be", 32'(bus_be), 32'h8);
    check("lb_addr", bus_addr, 32'h100);
    next_cycle();
    bus_ack = 1; bus_rdata = 32'h80FF0000;
    sample();
    check("lb_c2_stall", 32'(stall), 1);
    next_cycle();
    bus_ack = 0;
    sample();
    check("lb_rdata", rdata, 32'hFFFFFF80);
    next_cycle();
    request(0, 0, 0, 0, 3'd0);
    next_cycle();

    // lbu 0x103
    request(0, 1, 32'h103, 0, 3'd4);
    next_cycle();
    bus_ack = 1; bus_rdata = 32'h80FF0000;
    next_cycle();
    bus_ack = 0;
    sample();
    check("lbu_rdata", rdata, 32'h00000080);
    next_cycle();
    request(0, 0, 0, 0, 3'd0);
    next_cycle();

    // lw 0x200 with no ack: four WAIT cycles then timeout
    request(0, 1, 32'h200, 0, 3'd0);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      sample();
      check($sformatf("tmo_w%0d_req", i), 32'(bus_req), 1);
      check($sformatf("tmo_w%0d_stall", i), 32'(stall), 1);
    end
    next_cycle();
    sample();
    check("tmo_done_err", 32'(bus_err), 1);
    check("tmo_done_rdata", rdata, 0);
    check("tmo_done_stall", 32'(stall), 0);
    check("tmo_done_req", 32'(bus_req), 0);
    next_cycle();
    request(0, 0, 0, 0, 3'd0);
    sample();
    check("tmo_idle_err", 32'(bus_err), 0);

    // lw 0x300, ack coincides with timeout cycle: ack wins
    next_cycle();
    request(0, 1, 32'h300, 0, 3'd0);
    for (int i = 1; i <= 3; i++) next_cycle();
    next_cycle();
    bus_ack = 1; bus_rdata = 32'hCAFEF00D;
    next_cycle();
    bus_ack = 0;
    sample();
    check("race_err", 32'(bus_err), 0);
    check("race_rdata", rdata, 32'hCAFEF00D);
    next_cycle();
    request(0, 0, 0, 0, 3'd0);

    // lh 0x102 sign extension from the upper half
    request(0, 1, 32'h102, 0, 3'd1);
    next_cycle();
    bus_ack = 1; bus_rdata = 32'h9ABC1234;
    next_cycle();
    bus_ack = 0;
    sample();
    check("lh_rdata", rdata, 32'hFFFF9ABC);
    next_cycle();
    request(0, 0, 0, 0, 3'd0);
    next_cycle();

    // reset in the 2nd WAIT cycle abandons the access
    request(0, 1, 32'h400, 0, 3'd0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    sample();
    check("rstw_stall_during", 32'(stall), 0);
    next_cycle();
    reset = 1'b0;
    request(0, 0, 0, 0, 3'd0);
    sample();
    check("rstw_req", 32'(bus_req), 0);
    check("rstw_stall", 32'(stall), 0);
    next_cycle();
    bus_ack = 1; bus_rdata = 32'hDEADBEEF;
    next_cycle();
    bus_ack = 0;
    sample();
    check("rstw_rdata", rdata, 0);
    check("rstw_err", 32'(bus_err), 0);
    check("rstw_req_late", 32'(bus_req), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
